periph_arb: RTL and testbench
=============================

# periph_arb

Two-master arbiter and access sequencer for the peripheral bus. Master 0 is the CPU load/store port and master 1 is the DMA engine. The block serialises their requests onto the single-master `periph_bus` port (`o_addr/o_sel/o_we/o_re/o_wdata`, `i_rdata/i_rdy`). It holds each access until the selected peripheral signals ready, then returns read data and a one-cycle acknowledge to the owning master. An optional watchdog aborts accesses that never complete.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles spent in ACCESS before abort. Range 1..65535.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 means master 0 always wins ties.

Ports:
- `i_clk`  in  1  — system clock; all state is on the rising edge.
- `i_rst_n`  in  1  — reset, asynchronous, active-low.
- `i_m0_req`, `i_m1_req`  in  1  — access request. The master holds it, with its command, stable until ack.
- `i_m0_addr`, `i_m1_addr`  in  16  — access address.
- `i_m0_we`, `i_m1_we`  in  1  — write enable.
- `i_m0_re`, `i_m1_re`  in  1  — read enable.
- `i_m0_wdata`, `i_m1_wdata`  in  16  — write data.
- `o_m0_ack`, `o_m1_ack`  out  1  — one-cycle completion pulse.
- `o_m0_rdata`, `o_m1_rdata`  out  16  — read data; valid while the matching ack is high.
- `o_m0_err`, `o_m1_err`  out  1  — access aborted by timeout; valid with ack.
- `o_addr`  out  16  — address to the peripheral bus.
- `o_sel`  out  1  — bus select.
- `o_we`  out  1  — bus write enable.
- `o_re`  out  1  — bus read enable.
- `o_wdata`  out  16  — bus write data.
- `i_rdata`  in  16  — bus read data.
- `i_rdy`  in  1  — bus ready.
- `o_busy`  out  1  — high when the state is not IDLE.

## Operation
- State machine with three states: IDLE, ACCESS, DONE.
- **IDLE**
  - If any request is high, pick a winner and latch that master's addr, we, re and wdata into the command register. Record the winner in `owner` and move to ACCESS.
  - If no request is high, remain in IDLE.
- **Arbitration**
  - With a single request, that master wins.
  - With both requests and round-robin, the master that is not `last_grant` wins.
  - With both requests and FIXED_PRIO=1, master 0 wins.
  - `last_grant` updates on every grant. It resets to 1, so master 0 wins the first tie.
- **Command sanitising at latch**
  - If both we and re are set, write wins and re is latched as 0.
  - If both are 0, the access is still issued with sel high and returns rdata 0.
- **ACCESS**
  - `o_sel` is 1. `o_addr/o_we/o_re/o_wdata` come from the command register and are stable for the whole state.
  - When `i_rdy` is 1, capture `i_rdata` (forced to 0 when the latched re is 0) and move to DONE.
- **DONE**
  - `o_mX_ack` is 1 for the owner only and `o_sel` is 0.
  - Requests are ignored in this state. Next state is IDLE.
- **Master obligation:** deassert req on the edge that ends its ack cycle. A req still high in the following IDLE is treated as a new access.
- Non-owner outputs: ack 0, err 0, and rdata holds its last value.
- **Reset (async)**
  - Any state returns to IDLE.
  - All outputs go to 0: o_sel, o_we, o_re, o_addr, o_wdata, both acks, both errs, both rdata, o_busy.
  - `last_grant` goes to 1 and the watchdog counter goes to 0.
  - A transaction in flight is dropped and never acked.

## Timing
- Request sampled high in cycle N, in IDLE:
  - `o_sel` is high in N+1.
  - If `i_rdy` is high in N+1, ack is high in N+2 and the block is back in IDLE at N+3.
- Minimum access is 3 cycles. Back-to-back throughput is one access per 3 cycles.
- Each extra wait cycle (`i_rdy` low in ACCESS) adds exactly one cycle.
- `o_sel` is never high in two adjacent accesses without a low cycle between them. The low cycle is DONE.
- Request changes during ACCESS or DONE have no effect on the bus.

## Configuration
- `PERIPH_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering ACCESS and increments each ACCESS cycle with `i_rdy` low.
  - When the count reaches TIMEOUT, the next state is DONE with err=1 and rdata=0 for the owner.
  - `i_rdy` arriving in the same cycle as expiry wins: normal completion, err=0.
- `PERIPH_ARB_TIMEOUT_EN` undefined:
  - No counter is built; ACCESS waits indefinitely.
  - `o_m0_err` and `o_m1_err` are constant 0.

## Structure
- Package `periph_arb_pkg`:
  - state encoding localparams: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2 (2'd3 decodes to IDLE);
  - master indices M_CPU=0, M_DMA=1;
  - default TIMEOUT=255.
- Sub-module `periph_wdog` holds the timeout counter. Its ports are i_clk, i_rst_n, i_clr, i_inc, o_expired.
  - It is instantiated only under `PERIPH_ARB_TIMEOUT_EN`.
- The arbiter, command register and FSM live in `periph_arb`.

## Test plan
- **Single access:** m0 reads 0x0302 and the bus returns `i_rdy`=1 at once with `i_rdata`=0xA5A5. Expect o_sel high for exactly 1 cycle and o_m0_ack 2 cycles after req, with rdata 0xA5A5 and err 0.
- **Tie, round-robin:** after reset, m0 and m1 assert req together and hold it. Expect grant order m0, m1, m0, m1. Each ack lands 3 cycles after the previous one and only ever goes to the master that was granted.
- **Wait states:** m1 writes 0x1234 to 0x0200 and `i_rdy` is held low for 5 cycles. Expect o_sel high for 6 cycles with o_addr 0x0200, o_we 1 and o_wdata 0x1234 stable throughout, then o_m1_ack.
- **Timeout (macro on, TIMEOUT=4):** m0 reads and `i_rdy` never rises. Expect o_sel high for 5 cycles, then o_m0_ack=1, o_m0_err=1, o_m0_rdata=0. Repeat with `i_rdy` rising on the expiry cycle: expect err=0.
- **Reset mid-access:** drop i_rst_n while in ACCESS. Expect o_sel, acks and o_busy at 0 immediately (asynchronous) and no ack after release. The next tie goes to m0.
- **Sanitising:** a request with we=re=1 puts o_we=1, o_re=0 on the bus. A request with we=re=0 returns rdata 0.

Source files
------------

// File: rtl/periph_arb_pkg.sv
// ---------------------------------------------------------------------------
// periph_arb_pkg
//   Shared definitions for the two-master peripheral bus arbiter:
//   FSM state encoding, master indices, default watchdog limit, the latched
//   command record and the small helpers used at grant time.
// ---------------------------------------------------------------------------
package periph_arb_pkg;

    // FSM state encoding; 2'd3 is unused and decodes as IDLE.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // Master indices.
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    // Default watchdog limit in ACCESS cycles.
    localparam int unsigned DEF_TIMEOUT = 255;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // One bus command, as held for the whole ACCESS state.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              re;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Build the command to latch: a request with both we and re set is
    // treated as a write, so re is dropped.
    function automatic cmd_t sanitize_cmd(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic              re,
        input logic [DATA_W-1:0] wdata
    );
        cmd_t c;
        c.addr  = addr;
        c.we    = we;
        c.re    = re & ~we;
        c.wdata = wdata;
        return c;
    endfunction

    // Grant decision. A lone request always wins; on a tie, fixed priority
    // favours the CPU, otherwise the master that was not granted last wins.
    function automatic logic pick_winner(
        input logic req0,
        input logic req1,
        input logic last_grant,
        input logic fixed_prio
    );
        if (req0 && req1) begin
            return fixed_prio ? M_CPU : ~last_grant;
        end
        return req1 ? M_DMA : M_CPU;
    endfunction

endpackage

// File: rtl/periph_wdog.sv
// ---------------------------------------------------------------------------
// periph_wdog
//   16-bit watchdog counter for a bus access. Cleared when an access starts,
//   advanced on every ACCESS cycle in which the peripheral is not ready.
//   o_expired is high once the count has reached TIMEOUT.
//
//   Ports:
//     i_clk      system clock (rising edge)
//     i_rst_n    asynchronous active-low reset
//     i_clr      clear the counter (access starting)
//     i_inc      count one wait cycle
//     o_expired  count has reached TIMEOUT
// ---------------------------------------------------------------------------
module periph_wdog
    import periph_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != 16'hFFFF)) begin
            // Saturate rather than wrap so a stuck access cannot re-arm.
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next value from the same pre-edge state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/periph_arb.sv
// ---------------------------------------------------------------------------
// periph_arb
//   Two-master arbiter and access sequencer for the peripheral bus.
//   Master 0 is the CPU load/store port, master 1 the DMA engine. One access
//   at a time is latched into a command register and held on the bus until
//   the peripheral is ready; the owner then gets one ack cycle with its read
//   data. Each access takes IDLE -> ACCESS (>=1 cycle) -> DONE.
//
//   Optional feature (macro PERIPH_ARB_TIMEOUT_EN): a watchdog aborts an
//   access after TIMEOUT not-ready ACCESS cycles and flags err with the ack.
//   Without the macro ACCESS waits indefinitely and both err outputs are 0.
//
//   Parameters:
//     TIMEOUT     watchdog limit in ACCESS cycles (1..65535)
//     FIXED_PRIO  0: round-robin on ties, 1: master 0 always wins ties
//
//   Ports:
//     i_clk, i_rst_n                  clock, asynchronous active-low reset
//     i_mX_req/addr/we/re/wdata       master X request and command
//     o_mX_ack/rdata/err              master X completion, read data, abort
//     o_addr/o_sel/o_we/o_re/o_wdata  peripheral bus command
//     i_rdata/i_rdy                   peripheral bus response
//     o_busy                          an access is in progress
// ---------------------------------------------------------------------------
module periph_arb
    import periph_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_we,
    input  logic              i_m0_re,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_err,

    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_we,
    input  logic              i_m1_re,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_err,

    output logic [ADDR_W-1:0] o_addr,
    output logic              o_sel,
    output logic              o_we,
    output logic              o_re,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_rdy,

    output logic              o_busy
);

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic              last_grant_q, last_grant_d;
    cmd_t              cmd_q,        cmd_d;
    logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;
    logic              err_q,        err_d;

    logic              winner;
    logic [DATA_W-1:0] rd_value;
    logic              wd_clr;
    logic              wd_inc;
    logic              wd_expired;

    assign winner = pick_winner(i_m0_req, i_m1_req, last_grant_q, FIXED_PRIO);

    // A command without read enable returns zero instead of bus data.
    assign rd_value = cmd_q.re ? i_rdata : '0;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        err_d        = err_q;
        wd_clr       = 1'b0;
        wd_inc       = 1'b0;

        case (state_q)
            ACCESS: begin
                // Ready beats an expiry in the same cycle.
                if (i_rdy) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                    if (owner_q == M_DMA) begin
                        m1_rdata_d = rd_value;
                    end else begin
                        m0_rdata_d = rd_value;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (owner_q == M_DMA) begin
                        m1_rdata_d = '0;
                    end else begin
                        m0_rdata_d = '0;
                    end
                end else begin
                    wd_inc = 1'b1;
                end
            end

            DONE: begin
                // Requests are ignored here; this cycle also keeps o_sel low
                // between back-to-back accesses.
                state_d = IDLE;
            end

            default: begin
                // IDLE (and the unused encoding 2'd3).
                if (i_m0_req || i_m1_req) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    cmd_d        = (winner == M_DMA)
                                 ? sanitize_cmd(i_m1_addr, i_m1_we, i_m1_re, i_m1_wdata)
                                 : sanitize_cmd(i_m0_addr, i_m0_we, i_m0_re, i_m0_wdata);
                    wd_clr       = 1'b1;
                    state_d      = ACCESS;
                end
            end
        endcase
    end

    // NOTE: the read-data holding registers are reset as well, because the
    // masters see them directly and must read 0 after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            owner_q      <= M_CPU;
            last_grant_q <= M_DMA;   // so the CPU wins the first tie
            cmd_q        <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            err_q        <= err_d;
        end
    end

`ifdef PERIPH_ARB_TIMEOUT_EN
    periph_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (wd_clr),
        .i_inc     (wd_inc),
        .o_expired (wd_expired)
    );

    assign o_m0_err = o_m0_ack & err_q;
    assign o_m1_err = o_m1_ack & err_q;
`else
    assign wd_expired = 1'b0;
    assign o_m0_err   = 1'b0;
    assign o_m1_err   = 1'b0;

    // Watchdog hooks have no load without the counter.
    logic wdog_unused;
    assign wdog_unused = ^{wd_clr, wd_inc, err_q, 16'(TIMEOUT)};
`endif

    // Bus side: command register drives the bus, select only in ACCESS.
    assign o_sel   = (state_q == ACCESS);
    assign o_addr  = cmd_q.addr;
    assign o_we    = cmd_q.we;
    assign o_re    = cmd_q.re;
    assign o_wdata = cmd_q.wdata;

    // Master side: ack only to the owner, during DONE.
    assign o_m0_ack   = (state_q == DONE) && (owner_q == M_CPU);
    assign o_m1_ack   = (state_q == DONE) && (owner_q == M_DMA);
    assign o_m0_rdata = m0_rdata_q;
    assign o_m1_rdata = m1_rdata_q;

    assign o_busy = (state_q == ACCESS) || (state_q == DONE);

endmodule

// File: tb/tb_periph_arb.sv
// ---------------------------------------------------------------------------
// tb_periph_arb
//   Self-checking bench for periph_arb: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   transaction-level model of the arbiter.
// ---------------------------------------------------------------------------
module tb_periph_arb;

    localparam int TB_TIMEOUT = 4;
    localparam bit TB_FIXED   = 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
    localparam int WAITS  = 3;
`else
    localparam bit TMO_ON = 1'b0;
    localparam int WAITS  = 5;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_m0_req = 1'b0, i_m0_we = 1'b0, i_m0_re = 1'b0;
    logic [15:0] i_m0_addr = '0, i_m0_wdata = '0;
    logic        i_m1_req = 1'b0, i_m1_we = 1'b0, i_m1_re = 1'b0;
    logic [15:0] i_m1_addr = '0, i_m1_wdata = '0;
    logic [15:0] i_rdata = '0;
    logic        i_rdy = 1'b0;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [15:0] o_m0_rdata, o_m1_rdata;
    logic [15:0] o_addr, o_wdata;
    logic        o_sel, o_we, o_re, o_busy;

    always #5 i_clk = ~i_clk;

    periph_arb #(
        .TIMEOUT    (TB_TIMEOUT),
        .FIXED_PRIO (TB_FIXED)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_m0_req   (i_m0_req),
        .i_m0_addr  (i_m0_addr),
        .i_m0_we    (i_m0_we),
        .i_m0_re    (i_m0_re),
        .i_m0_wdata (i_m0_wdata),
        .o_m0_ack   (o_m0_ack),
        .o_m0_rdata (o_m0_rdata),
        .o_m0_err   (o_m0_err),
        .i_m1_req   (i_m1_req),
        .i_m1_addr  (i_m1_addr),
        .i_m1_we    (i_m1_we),
        .i_m1_re    (i_m1_re),
        .i_m1_wdata (i_m1_wdata),
        .o_m1_ack   (o_m1_ack),
        .o_m1_rdata (o_m1_rdata),
        .o_m1_err   (o_m1_err),
        .o_addr     (o_addr),
        .o_sel      (o_sel),
        .o_we       (o_we),
        .o_re       (o_re),
        .o_wdata    (o_wdata),
        .i_rdata    (i_rdata),
        .i_rdy      (i_rdy),
        .o_busy     (o_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_acc: a command is on the bus; m_ack: the owner's ack cycle.
    bit          m_acc, m_ack, m_own, m_last, m_err, m_we, m_re;
    logic [15:0] m_addr, m_wdata, m_rd0, m_rd1;
    int          m_waits;
    int          done0, done1;
    bit          grant_w;

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return TB_FIXED ? 1'b0 : ~last;
        return r1;
    endfunction

    assign grant_w = pick(i_m0_req, i_m1_req, m_last);

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_acc <= 0; m_ack <= 0; m_own <= 0; m_last <= 1; m_err <= 0;
            m_we <= 0; m_re <= 0; m_addr <= '0; m_wdata <= '0;
            m_rd0 <= '0; m_rd1 <= '0; m_waits <= 0;
        end else if (m_ack) begin
            m_ack <= 0;
            if (m_own) done1 <= done1 + 1;
            else       done0 <= done0 + 1;
        end else if (m_acc) begin
            if (i_rdy) begin
                m_acc <= 0; m_ack <= 1; m_err <= 0;
                if (m_own) m_rd1 <= m_re ? i_rdata : 16'h0;
                else       m_rd0 <= m_re ? i_rdata : 16'h0;
            end else if (TMO_ON && m_waits >= TB_TIMEOUT) begin
                m_acc <= 0; m_ack <= 1; m_err <= 1;
                if (m_own) m_rd1 <= 16'h0;
                else       m_rd0 <= 16'h0;
            end else begin
                m_waits <= m_waits + 1;
            end
        end else if (i_m0_req || i_m1_req) begin
            m_own   <= grant_w;
            m_last  <= grant_w;
            m_addr  <= grant_w ? i_m1_addr  : i_m0_addr;
            m_wdata <= grant_w ? i_m1_wdata : i_m0_wdata;
            m_we    <= grant_w ? i_m1_we    : i_m0_we;
            m_re    <= grant_w ? (i_m1_re && !i_m1_we) : (i_m0_re && !i_m0_we);
            m_acc   <= 1;
            m_waits <= 0;
        end
    end

    task automatic compare();
        check("sel",    16'(o_sel),    16'(m_acc));
        check("busy",   16'(o_busy),   16'(m_acc | m_ack));
        check("m0_ack", 16'(o_m0_ack), 16'(m_ack & ~m_own));
        check("m1_ack", 16'(o_m1_ack), 16'(m_ack & m_own));
        check("m0_err", 16'(o_m0_err), 16'(m_ack & ~m_own & m_err));
        check("m1_err", 16'(o_m1_err), 16'(m_ack & m_own & m_err));
        check("m0_rdata", o_m0_rdata, m_rd0);
        check("m1_rdata", o_m1_rdata, m_rd1);
        if (m_acc) begin
            check("bus_addr",  o_addr,      m_addr);
            check("bus_we",    16'(o_we),   16'(m_we));
            check("bus_re",    16'(o_re),   16'(m_re));
            check("bus_wdata", o_wdata,     m_wdata);
        end
    endtask

    bit chk_en = 0;
    always @(negedge i_clk) begin
        if (chk_en) compare();
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_m(input bit m, input bit req, input logic [15:0] addr,
                           input bit we, input bit re, input logic [15:0] wd);
        if (m) begin
            i_m1_req = req; i_m1_addr = addr; i_m1_we = we; i_m1_re = re; i_m1_wdata = wd;
        end else begin
            i_m0_req = req; i_m0_addr = addr; i_m0_we = we; i_m0_re = re; i_m0_wdata = wd;
        end
    endtask

    task automatic rand_req(input bit m);
        drive_m(m, 1'b1, 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom));
    endtask

    // One access from master m; i_rdy stays low for `waits` ACCESS cycles
    // (never rises when waits < 0). Cycle 0 is the cycle req is first high.
    task automatic run_access(input bit m, input logic [15:0] addr, input bit we, input bit re,
                              input logic [15:0] wd, input logic [15:0] rdat, input int waits,
                              output int sel_cnt, output int ack_cyc, output bit err,
                              output logic [15:0] rd, output logic [15:0] b_addr,
                              output bit b_we, output bit b_re, output logic [15:0] b_wd,
                              output bit stable);
        bit first;
        step();
        drive_m(m, 1'b1, addr, we, re, wd);
        i_rdy = (waits == 0);
        i_rdata = rdat;
        sel_cnt = 0; ack_cyc = -1; stable = 1; first = 1; err = 0; rd = '0;
        b_addr = '0; b_we = 0; b_re = 0; b_wd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_sel) begin
                sel_cnt++;
                if (first) begin
                    b_addr = o_addr; b_we = o_we; b_re = o_re; b_wd = o_wdata; first = 0;
                end else if (o_addr !== b_addr || o_we !== b_we || o_re !== b_re || o_wdata !== b_wd) begin
                    stable = 0;
                end
            end
            if (m ? o_m1_ack : o_m0_ack) begin
                ack_cyc = i;
                err = m ? o_m1_err : o_m0_err;
                rd  = m ? o_m1_rdata : o_m0_rdata;
                break;
            end
            @(posedge i_clk);
            #1;
            if (waits >= 0 && i + 1 >= waits + 1) i_rdy = 1'b1;
        end
        step();
        drive_m(m, 1'b0, addr, we, re, wd);
        i_rdy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 1000000", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int sc, ac, ack_i, seen0, seen1;
        bit er, bwe, bre, st, seen;
        logic [15:0] rd, ba, bwd;
        int ack_cyc_q[$];
        bit ack_m_q[$];

        // Reset state.
        #12;
        check("rst_sel", 16'(o_sel), 16'h0);
        check("rst_busy", 16'(o_busy), 16'h0);
        check("rst_acks", 16'({o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}), 16'h0);
        check("rst_rdata0", o_m0_rdata, 16'h0);
        check("rst_rdata1", o_m1_rdata, 16'h0);
        check("rst_bus", 16'({o_we, o_re}), 16'h0);
        check("rst_addr", o_addr, 16'h0);
        check("rst_wdata", o_wdata, 16'h0);
        #10;
        i_rst_n = 1'b1;
        chk_en = 1;

        // Tie after reset, both requests held: m0, m1, m0, m1 every 3 cycles.
        step();
        drive_m(0, 1'b1, 16'h0010, 1'b0, 1'b1, 16'h0);
        drive_m(1, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0);
        i_rdy = 1'b1; i_rdata = 16'h0C0C;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            if (o_m0_ack) begin ack_cyc_q.push_back(i); ack_m_q.push_back(1'b0); end
            if (o_m1_ack) begin ack_cyc_q.push_back(i); ack_m_q.push_back(1'b1); end
        end
        step();
        drive_m(0, 1'b0, 16'h0010, 1'b0, 1'b1, 16'h0);
        drive_m(1, 1'b0, 16'h0020, 1'b0, 1'b1, 16'h0);
        i_rdy = 1'b0;
        check("tie_ack_count", 16'(ack_cyc_q.size()), 16'd4);
        for (int k = 0; k < 4 && k < ack_cyc_q.size(); k++) begin
            check("tie_ack_cycle", 16'(ack_cyc_q[k]), 16'(2 + 3 * k));
            check("tie_ack_master", 16'(ack_m_q[k]), 16'(k % 2));
        end

        // Single read with immediate ready.
        run_access(0, 16'h0302, 0, 1, 16'h0, 16'hA5A5, 0, sc, ac, er, rd, ba, bwe, bre, bwd, st);
        check("single_sel_cycles", 16'(sc), 16'd1);
        check("single_ack_cycle", 16'(ac), 16'd2);
        check("single_rdata", rd, 16'hA5A5);
        check("single_err", 16'(er), 16'h0);
        check("single_addr", ba, 16'h0302);
        check("single_re", 16'(bre), 16'h1);

        // Write with wait states.
        run_access(1, 16'h0200, 1, 0, 16'h1234, 16'h0, WAITS, sc, ac, er, rd, ba, bwe, bre, bwd, st);
        check("wait_sel_cycles", 16'(sc), 16'(WAITS + 1));
        check("wait_ack_cycle", 16'(ac), 16'(WAITS + 2));
        check("wait_addr", ba, 16'h0200);
        check("wait_we", 16'(bwe), 16'h1);
        check("wait_wdata", bwd, 16'h1234);
        check("wait_stable", 16'(st), 16'h1);
        check("wait_err", 16'(er), 16'h0);

        // Sanitising: we=re=1 is a write; we=re=0 returns 0.
        run_access(0, 16'h0111, 1, 1, 16'hBEEF, 16'h5555, 0, sc, ac, er, rd, ba, bwe, bre, bwd, st);
        check("sanit_we", 16'(bwe), 16'h1);
        check("sanit_re", 16'(bre), 16'h0);
        check("sanit_wr_rdata", rd, 16'h0);
        run_access(1, 16'h0122, 0, 0, 16'h0, 16'hFFFF, 0, sc, ac, er, rd, ba, bwe, bre, bwd, st);
        check("sanit_none_sel", 16'(sc), 16'd1);
        check("sanit_none_rdata", rd, 16'h0);

`ifdef PERIPH_ARB_TIMEOUT_EN
        // Watchdog expiry, then ready on the expiry cycle.
        run_access(0, 16'h0333, 0, 1, 16'h0, 16'h7777, -1, sc, ac, er, rd, ba, bwe, bre, bwd, st);
        check("tmo_sel_cycles", 16'(sc), 16'd5);
        check("tmo_ack_cycle", 16'(ac), 16'd6);
        check("tmo_err", 16'(er), 16'h1);
        check("tmo_rdata", rd, 16'h0);
        run_access(0, 16'h0333, 0, 1, 16'h0, 16'h7777, 4, sc, ac, er, rd, ba, bwe, bre, bwd, st);
        check("tmo_race_sel_cycles", 16'(sc), 16'd5);
        check("tmo_race_err", 16'(er), 16'h0);
        check("tmo_race_rdata", rd, 16'h7777);
`endif

        // Reset in the middle of an access.
        step();
        drive_m(0, 1'b1, 16'h0400, 1'b0, 1'b1, 16'h0);
        i_rdy = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("pre_rst_busy", 16'(o_busy), 16'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_sel", 16'(o_sel), 16'h0);
        check("midrst_busy", 16'(o_busy), 16'h0);
        check("midrst_acks", 16'({o_m0_ack, o_m1_ack}), 16'h0);
        drive_m(0, 1'b0, 16'h0400, 1'b0, 1'b1, 16'h0);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_m0_ack || o_m1_ack) seen = 1;
        end
        check("no_ack_after_rst", 16'(seen), 16'h0);

        // First tie after reset goes to m0.
        step();
        drive_m(0, 1'b1, 16'h0500, 1'b0, 1'b1, 16'h0);
        drive_m(1, 1'b1, 16'h0600, 1'b0, 1'b1, 16'h0);
        i_rdy = 1'b1;
        ack_i = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_m0_ack || o_m1_ack) begin
                ack_i = i;
                check("rst_tie_m0_ack", 16'(o_m0_ack), 16'h1);
                check("rst_tie_m1_ack", 16'(o_m1_ack), 16'h0);
                break;
            end
        end
        check("rst_tie_ack_cycle", 16'(ack_i), 16'd2);
        step();
        drive_m(0, 1'b0, 16'h0500, 1'b0, 1'b1, 16'h0);
        drive_m(1, 1'b0, 16'h0600, 1'b0, 1'b1, 16'h0);
        i_rdy = 1'b0;
        repeat (3) step();

        // Randomized traffic; masters drop req on the edge ending their ack.
        seen0 = done0;
        seen1 = done1;
        repeat (3000) begin
            step();
            if (i_m0_req && done0 != seen0) begin
                seen0 = done0;
                i_m0_req = 1'b0;
                if ($urandom_range(3) == 0) rand_req(0);
            end else if (!i_m0_req && $urandom_range(2) == 0) begin
                rand_req(0);
            end
            if (i_m1_req && done1 != seen1) begin
                seen1 = done1;
                i_m1_req = 1'b0;
                if ($urandom_range(3) == 0) rand_req(1);
            end else if (!i_m1_req && $urandom_range(2) == 0) begin
                rand_req(1);
            end
            i_rdy   = ($urandom_range(3) != 0);
            i_rdata = 16'($urandom);
        end

        @(negedge i_clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
